// File: rtl/edge_event_arbiter.sv
// Edge event arbiter: synchronises N_CH asynchronous level inputs, captures their
// rising/falling edges as pending events and hands them out one at a time,
// round-robin across channels, over a valid/ready channel.
module edge_event_arbiter #(
  parameter  int unsigned N_CH        = 4,
  parameter  int unsigned SYNC_STAGES = 2,
  localparam int unsigned CH_W        = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] level,
  input  logic [N_CH-1:0] rise_en,
  input  logic [N_CH-1:0] fall_en,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [CH_W-1:0] evt_ch,
  output logic            evt_rise,
  output logic [N_CH-1:0] overflow,
  input  logic [N_CH-1:0] ovf_clr
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_OFFER = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [N_CH-1:0] r_sync [SYNC_STAGES];
  logic [N_CH-1:0] r_prev;
  logic [N_CH-1:0] r_pend_r;
  logic [N_CH-1:0] r_pend_f;
  logic [N_CH-1:0] r_ovf;
  logic [CH_W-1:0] r_rr_ptr;
  logic [CH_W-1:0] r_evt_ch;
  logic            r_evt_valid;
  logic            r_evt_rise;

  logic [N_CH-1:0] w_s;
  logic [N_CH-1:0] w_rise;
  logic [N_CH-1:0] w_fall;
  logic [N_CH-1:0] w_pend_any;
  logic [N_CH-1:0] w_gnt_r;
  logic [N_CH-1:0] w_gnt_f;
  logic [N_CH-1:0] w_pend_r_nxt;
  logic [N_CH-1:0] w_pend_f_nxt;
  logic [N_CH-1:0] w_ovf_nxt;
  logic            w_hs;
  logic            w_found;
  logic [CH_W-1:0] w_idx;
  logic [CH_W-1:0] w_sel;
  logic            w_valid_nxt;
  logic [CH_W-1:0] w_evt_ch_nxt;
  logic            w_evt_rise_nxt;
  logic [CH_W-1:0] w_rr_nxt;

  assign w_s        = r_sync[SYNC_STAGES-1];
  assign w_rise     = w_s & ~r_prev & rise_en;
  assign w_fall     = ~w_s & r_prev & fall_en;
  assign w_pend_any = r_pend_r | r_pend_f;
  assign w_hs       = r_evt_valid & evt_ready;

  assign evt_valid  = r_evt_valid;
  assign evt_ch     = r_evt_ch;
  assign evt_rise   = r_evt_rise;
  assign overflow   = r_ovf;

  // Synchroniser chain and previous-sample register for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
      r_prev <= '0;
    end else begin
      r_sync[0] <= level;
      for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
      r_prev <= w_s;
    end
  end

  // Decode which pending bit the current handshake retires
  always_comb begin
    w_gnt_r = '0;
    w_gnt_f = '0;
    if (w_hs) begin
      if (r_evt_rise) w_gnt_r[r_evt_ch] = 1'b1;
      else            w_gnt_f[r_evt_ch] = 1'b1;
    end
  end

  // Pending-bit update; an edge landing on a still-pending, ungranted bit merges and flags overflow
  always_comb begin
    w_pend_r_nxt = r_pend_r & ~w_gnt_r;
    w_pend_f_nxt = r_pend_f & ~w_gnt_f;
    w_ovf_nxt    = r_ovf & ~ovf_clr;
    for (int i = 0; i < N_CH; i++) begin
      if (w_rise[i]) begin
        if (r_pend_r[i] && !w_gnt_r[i]) w_ovf_nxt[i] = 1'b1;
        w_pend_r_nxt[i] = 1'b1;
      end
      if (w_fall[i]) begin
        if (r_pend_f[i] && !w_gnt_f[i]) w_ovf_nxt[i] = 1'b1;
        w_pend_f_nxt[i] = 1'b1;
      end
    end
  end

  // Pending and overflow registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend_r <= '0;
      r_pend_f <= '0;
      r_ovf    <= '0;
    end else begin
      r_pend_r <= w_pend_r_nxt;
      r_pend_f <= w_pend_f_nxt;
      r_ovf    <= w_ovf_nxt;
    end
  end

  // Next-state and offer logic: round-robin pick in IDLE, hold until handshake in OFFER
  always_comb begin
    w_state_nxt    = r_state;
    w_valid_nxt    = r_evt_valid;
    w_evt_ch_nxt   = r_evt_ch;
    w_evt_rise_nxt = r_evt_rise;
    w_rr_nxt       = r_rr_ptr;
    w_found        = 1'b0;
    w_sel          = r_rr_ptr;
    w_idx          = r_rr_ptr;
    for (int k = 0; k < N_CH; k++) begin
      w_idx = CH_W'((int'(r_rr_ptr) + k) % int'(N_CH));
      if (!w_found && w_pend_any[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt    = S_OFFER;
          w_valid_nxt    = 1'b1;
          w_evt_ch_nxt   = w_sel;
          // With both edges pending, the current level tells which came first
          w_evt_rise_nxt = r_pend_r[w_sel] & (~r_pend_f[w_sel] | ~w_s[w_sel]);
        end
      end
      S_OFFER: begin
        if (w_hs) begin
          w_state_nxt = S_IDLE;
          w_valid_nxt = 1'b0;
          w_rr_nxt    = (r_evt_ch == CH_W'(N_CH - 1)) ? '0 : r_evt_ch + CH_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Registered offer outputs and round-robin pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      r_evt_valid <= 1'b0;
      r_evt_ch    <= '0;
      r_evt_rise  <= 1'b0;
      r_rr_ptr    <= '0;
    end else begin
      r_evt_valid <= w_valid_nxt;
      r_evt_ch    <= w_evt_ch_nxt;
      r_evt_rise  <= w_evt_rise_nxt;
      r_rr_ptr    <= w_rr_nxt;
    end
  end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Self-checking bench for edge_event_arbiter: table-driven vectors plus directed
// sequences for hold/overflow, both-pending ordering, masking and mid-offer reset.
module tb_edge_event_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] level;
  logic [3:0] rise_en;
  logic [3:0] fall_en;
  logic [3:0] ovf_clr;
  logic       evt_ready;
  logic       evt_valid;
  logic [1:0] evt_ch;
  logic       evt_rise;
  logic [3:0] overflow;

  int n_checks;
  int n_err;

  typedef struct {
    logic       rst;
    logic [3:0] lvl;
    logic [3:0] fen;
    logic       rdy;
    logic       exp_v;
    logic [1:0] exp_ch;
    logic       exp_r;
    logic [3:0] exp_ovf;
  } vec_t;

  vec_t vecs[$];

  typedef struct {
    logic [1:0] ch;
    logic       rise;
  } evt_t;

  evt_t got[$];

  edge_event_arbiter #(.N_CH(4), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .level     (level),
    .rise_en   (rise_en),
    .fall_en   (fall_en),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_ch    (evt_ch),
    .evt_rise  (evt_rise),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic [3:0] lvl, input logic [3:0] fen,
                     input logic rdy, input logic v, input logic [1:0] ch, input logic r);
    vec_t t;
    t.rst = rst; t.lvl = lvl; t.fen = fen; t.rdy = rdy;
    t.exp_v = v; t.exp_ch = ch; t.exp_r = r; t.exp_ovf = 4'h0;
    vecs.push_back(t);
  endtask

  task automatic do_reset();
    level   = 4'h0;
    reset   = 1'b1;
    tick();
    tick();
    reset   = 1'b0;
  endtask

  // Record the offer visible now (if any), then keep ready high for n cycles recording offers
  task automatic collect(input int n);
    evt_t e;
    evt_ready = 1'b1;
    if (evt_valid) begin e.ch = evt_ch; e.rise = evt_rise; got.push_back(e); end
    for (int c = 0; c < n; c++) begin
      tick();
      if (evt_valid) begin e.ch = evt_ch; e.rise = evt_rise; got.push_back(e); end
    end
  endtask

  initial begin
    logic seen;
    logic hold_ok;
    evt_t e;
    n_checks  = 0;
    n_err     = 0;
    reset     = 1'b1;
    level     = 4'h0;
    rise_en   = 4'hF;
    fall_en   = 4'hF;
    ovf_clr   = 4'h0;
    evt_ready = 1'b0;

    // Test 1: single rise on ch2, valid SYNC_STAGES+1 edges after first sample
    add(1, 4'h0, 4'hF, 1, 0, 0, 0);
    add(0, 4'h4, 4'hF, 1, 0, 0, 0);
    add(0, 4'h4, 4'hF, 1, 0, 0, 0);
    add(0, 4'h4, 4'hF, 1, 0, 0, 0);
    add(0, 4'h4, 4'hF, 1, 1, 2, 1);
    add(0, 4'h4, 4'hF, 1, 0, 0, 0);
    add(0, 4'h4, 4'hF, 1, 0, 0, 0);
    add(0, 4'h4, 4'hF, 1, 0, 0, 0);
    // Test 2: ch0,1,3 rise together -> 0,1,3; new ch0 rise mid-burst served after ch3
    add(1, 4'h0, 4'h0, 1, 0, 0, 0);
    add(0, 4'hB, 4'h0, 1, 0, 0, 0);
    add(0, 4'hB, 4'h0, 1, 0, 0, 0);
    add(0, 4'hB, 4'h0, 1, 0, 0, 0);
    add(0, 4'hB, 4'h0, 1, 1, 0, 1);
    add(0, 4'hA, 4'h0, 1, 0, 0, 0);
    add(0, 4'hB, 4'h0, 1, 1, 1, 1);
    add(0, 4'hB, 4'h0, 1, 0, 0, 0);
    add(0, 4'hB, 4'h0, 1, 1, 3, 1);
    add(0, 4'hB, 4'h0, 1, 0, 0, 0);
    add(0, 4'hB, 4'h0, 1, 1, 0, 1);
    add(0, 4'hB, 4'h0, 1, 0, 0, 0);
    add(0, 4'hB, 4'h0, 1, 0, 0, 0);

    foreach (vecs[i]) begin
      reset     = vecs[i].rst;
      level     = vecs[i].lvl;
      fall_en   = vecs[i].fen;
      evt_ready = vecs[i].rdy;
      tick();
      chk($sformatf("vec%0d_valid", i), 32'(evt_valid), 32'(vecs[i].exp_v));
      if (vecs[i].exp_v) begin
        chk($sformatf("vec%0d_ch", i), 32'(evt_ch), 32'(vecs[i].exp_ch));
        chk($sformatf("vec%0d_rise", i), 32'(evt_rise), 32'(vecs[i].exp_r));
      end
      chk($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vecs[i].exp_ovf));
    end
    reset   = 1'b0;
    fall_en = 4'hF;

    // Test 3: ready low, two pulses on ch1 -> offer held, overflow[1] set, then cleared
    evt_ready = 1'b0;
    do_reset();
    hold_ok = 1'b1;
    for (int c = 0; c < 20; c++) begin
      level[1] = (c == 0 || c == 1 || c == 5 || c == 6);
      tick();
      if (c >= 3 && !(evt_valid === 1'b1 && evt_ch === 2'd1 && evt_rise === 1'b1)) hold_ok = 1'b0;
    end
    chk("t3_offer_held", 32'(hold_ok), 32'd1);
    chk("t3_overflow_set", 32'(overflow), 32'h2);
    ovf_clr = 4'h2;
    tick();
    ovf_clr = 4'h0;
    chk("t3_overflow_clr", 32'(overflow), 32'h0);
    evt_ready = 1'b1;
    tick();
    chk("t3_hs_valid", 32'(evt_valid), 32'd0);
    tick();
    chk("t3_fall_valid", 32'(evt_valid), 32'd1);
    chk("t3_fall_ch", 32'(evt_ch), 32'd1);
    chk("t3_fall_rise", 32'(evt_rise), 32'd0);
    tick();
    chk("t3_drained", 32'(evt_valid), 32'd0);

    // Test 4: ch1 high 4 cycles behind a ch0 offer -> both pending, rise then fall
    evt_ready = 1'b0;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      level = {2'b00, (c < 4), 1'b1};
      tick();
    end
    chk("t4_first_ch", 32'(evt_ch), 32'd0);
    chk("t4_first_valid", 32'(evt_valid), 32'd1);
    evt_ready = 1'b1;
    tick();
    chk("t4_hs0", 32'(evt_valid), 32'd0);
    tick();
    chk("t4_rise_valid", 32'(evt_valid), 32'd1);
    chk("t4_rise_ch", 32'(evt_ch), 32'd1);
    chk("t4_rise_type", 32'(evt_rise), 32'd1);
    tick();
    chk("t4_hs1", 32'(evt_valid), 32'd0);
    tick();
    chk("t4_fall_valid", 32'(evt_valid), 32'd1);
    chk("t4_fall_ch", 32'(evt_ch), 32'd1);
    chk("t4_fall_type", 32'(evt_rise), 32'd0);
    tick();
    tick();
    chk("t4_idle", 32'(evt_valid), 32'd0);

    // Test 5: fall pending before the mask is delivered; afterwards only rises on ch0
    evt_ready = 1'b0;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      level[0] = (c < 3);
      tick();
    end
    fall_en = 4'hE;
    got.delete();
    collect(8);
    chk("t5_pre_count", 32'(got.size()), 32'd2);
    if (got.size() == 2) begin
      chk("t5_pre0_rise", 32'(got[0].rise), 32'd1);
      chk("t5_pre1_rise", 32'(got[1].rise), 32'd0);
      chk("t5_pre1_ch", 32'(got[1].ch), 32'd0);
    end
    got.delete();
    for (int c = 0; c < 30; c++) begin
      level[0] = (c < 6) || (c >= 12);
      tick();
      if (evt_valid) begin e.ch = evt_ch; e.rise = evt_rise; got.push_back(e); end
    end
    chk("t5_mask_count", 32'(got.size()), 32'd2);
    foreach (got[i]) begin
      chk($sformatf("t5_mask%0d_rise", i), 32'(got[i].rise), 32'd1);
      chk($sformatf("t5_mask%0d_ch", i), 32'(got[i].ch), 32'd0);
    end
    fall_en = 4'hF;

    // Test 6: reset during an offer drops it and clears overflow; quiet until a new edge
    evt_ready = 1'b0;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      level[2] = (c < 2) || (c >= 5);
      tick();
    end
    chk("t6_offer_valid", 32'(evt_valid), 32'd1);
    chk("t6_offer_ch", 32'(evt_ch), 32'd2);
    chk("t6_ovf_before", 32'(overflow), 32'h4);
    level = 4'h0;
    reset = 1'b1;
    tick();
    chk("t6_valid_after_rst", 32'(evt_valid), 32'd0);
    chk("t6_ovf_after_rst", 32'(overflow), 32'h0);
    reset     = 1'b0;
    evt_ready = 1'b1;
    hold_ok   = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (evt_valid !== 1'b0) hold_ok = 1'b0;
    end
    chk("t6_quiet", 32'(hold_ok), 32'd1);
    level[3] = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 12 && !seen; c++) begin
      tick();
      if (evt_valid === 1'b1) begin
        seen = 1'b1;
        chk("t6_new_ch", 32'(evt_ch), 32'd3);
        chk("t6_new_rise", 32'(evt_rise), 32'd1);
      end
    end
    if (!seen) begin
      n_checks++;
      n_err++;
      $display("FAIL t6_new_event: no offer within 12 cycles, expected one on ch3");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
